// File: rtl/computer_8bit_pkg.sv
// Shared types for the 8-bit computer memory subsystem (arbiter state, bus owner).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package computer_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    // Default start of the ROM window; everything below it is RAM.
    localparam logic [15:0] ROM_BASE_DEF = 16'hF000;

    // The other requester, used to rotate priority on a tie.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_VID : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick between CPU (bit 0) and video (bit 1).
// Latency: combinational; the last-grant register lives in the parent.
// Backpressure: none; o_vld simply follows any active request.
//  i_req        : request vector {vid, cpu}
//  i_last_grant : owner granted on the previous tie
//  o_vld/o_grant: a grant is available / who gets it
module rr_arb2
    import computer_8bit_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_grant,
    output logic       o_vld,
    output owner_t     o_grant
);

    always_comb begin
        o_vld   = |i_req;
        o_grant = OWN_CPU;
        case (i_req)
            2'b10:   o_grant = OWN_VID;
            2'b11:   o_grant = other_owner(i_last_grant);
            default: o_grant = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port RAM/ROM bus between the CPU and the video fetch engine.
// Latency: request sampled at edge N -> read ack at edge N+1+MEM_LAT, write ack at edge N+2.
// Backpressure: requesters hold req (level) until their one-cycle ack; one access in flight.
//  CLOCK_50/res_n             : clock, async active-low reset
//  cpu_req/we/adr/wdata       : CPU access request; cpu_rdata/cpu_ack return path
//  vid_req/vid_adr            : video read request; vid_rdata/vid_ack return path
//  mem_adr/mem_wdata/ram_we   : registered memory bus; ram_rdata/rom_rdata read data
//  busy                       : high whenever an access is in progress
module mem_bus_arbiter
    import computer_8bit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEF
)
(
    input  logic              CLOCK_50,
    input  logic              res_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_adr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    arb_state_t        r_state;
    owner_t            r_owner;
    owner_t            r_last_grant;
    logic              r_we_lat;
    logic              r_rom_sel;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vid_rdata;
    logic              r_cpu_ack;
    logic              r_vid_ack;
    logic              r_busy;

    logic              w_gnt_vld;
    owner_t            w_gnt;
    logic [ADDR_W-1:0] w_gnt_adr;
    logic              w_gnt_we;
    logic              w_gnt_rom;
    logic [DATA_W-1:0] w_rdata;

    rr_arb2 u_rr_arb2 (
        .i_req        ({vid_req, cpu_req}),
        .i_last_grant (r_last_grant),
        .o_vld        (w_gnt_vld),
        .o_grant      (w_gnt)
    );

    assign w_gnt_adr = (w_gnt == OWN_CPU) ? cpu_adr : vid_adr;
    // Video is read-only, so its write flag is forced low regardless of cpu_we.
    assign w_gnt_we  = (w_gnt == OWN_CPU) && cpu_we;
    assign w_gnt_rom = (w_gnt_adr >= ROM_BASE);
    assign w_rdata   = r_rom_sel ? rom_rdata : ram_rdata;

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_VID;   // CPU wins the first tie
            r_we_lat     <= 1'b0;
            r_rom_sel    <= 1'b0;
            r_lat_cnt    <= '0;
            r_mem_adr    <= '0;
            r_mem_wdata  <= '0;
            r_ram_we     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vid_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_vid_ack    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ram_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner   <= w_gnt;
                        if (cpu_req && vid_req) begin
                            r_last_grant <= w_gnt;
                        end
                        r_mem_adr <= w_gnt_adr;
                        if (w_gnt == OWN_CPU) begin
                            r_mem_wdata <= cpu_wdata;
                        end
                        r_we_lat  <= w_gnt_we;
                        r_rom_sel <= w_gnt_rom;
                        r_lat_cnt <= CNT_W'(MEM_LAT);
                        // Write strobe lands in the first ACCESS cycle; ROM writes are dropped.
                        r_ram_we  <= w_gnt_we && !w_gnt_rom;
                        r_busy    <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_we_lat) begin
                        r_state <= DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                        if (r_lat_cnt == CNT_W'(1)) begin
                            if (r_owner == OWN_CPU) begin
                                r_cpu_rdata <= w_rdata;
                            end else begin
                                r_vid_rdata <= w_rdata;
                            end
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_cpu_ack <= (r_owner == OWN_CPU);
                    r_vid_ack <= (r_owner == OWN_VID);
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign vid_rdata = r_vid_rdata;
    assign vid_ack   = r_vid_ack;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign ram_we    = r_ram_we;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed latency/decode/arbitration cases plus random traffic.
// Latency: n/a.
// Backpressure: requesters hold req until ack, then drop it in the ack cycle.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance
    logic        cpu_req = 0, cpu_we = 0, vid_req = 0;
    logic [15:0] cpu_adr = '0, vid_adr = '0, mem_adr;
    logic [7:0]  cpu_wdata = '0, cpu_rdata, vid_rdata, mem_wdata, ram_rdata, rom_rdata;
    logic        cpu_ack, vid_ack, ram_we, busy;

    // MEM_LAT=3 instance
    logic        cpu_req3 = 0, cpu_we3 = 0, vid_req3 = 0;
    logic [15:0] cpu_adr3 = '0, vid_adr3 = '0, mem_adr3;
    logic [7:0]  cpu_wdata3 = '0, cpu_rdata3, vid_rdata3, mem_wdata3, ram_rdata3, rom_rdata3;
    logic        cpu_ack3, vid_ack3, ram_we3, busy3;

    mem_bus_arbiter #(.MEM_LAT(1)) dut (
        .CLOCK_50(clk), .res_n(res_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.MEM_LAT(3)) dut3 (
        .CLOCK_50(clk), .res_n(res_n),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_adr(cpu_adr3), .cpu_wdata(cpu_wdata3),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
        .vid_req(vid_req3), .vid_adr(vid_adr3), .vid_rdata(vid_rdata3), .vid_ack(vid_ack3),
        .mem_adr(mem_adr3), .mem_wdata(mem_wdata3), .ram_we(ram_we3),
        .ram_rdata(ram_rdata3), .rom_rdata(rom_rdata3), .busy(busy3)
    );

    // Memory models: RAM array plus a fixed ROM pattern, both read from the bus address.
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return (a == 16'hF000) ? 8'hEA : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [7:0] expect_rd(input logic [15:0] a);
        return (a >= 16'hF000) ? rom_val(a) : ref_mem[a];
    endfunction

    assign ram_rdata  = ram[mem_adr];
    assign rom_rdata  = rom_val(mem_adr);
    assign ram_rdata3 = ram[mem_adr3];
    assign rom_rdata3 = rom_val(mem_adr3);

    always @(posedge clk) begin
        if (ram_we) ram[mem_adr] <= mem_wdata;
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Invariants on the MEM_LAT=1 instance.
    logic mon_en = 1'b0;
    logic prev_cack = 1'b0, prev_vack = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ack_excl", {31'b0, cpu_ack & vid_ack}, 0);
            if (ram_we)  chk("we_in_rom", {31'b0, mem_adr >= 16'hF000}, 0);
            if (cpu_ack) chk("cpu_ack_width", {31'b0, prev_cack}, 0);
            if (vid_ack) chk("vid_ack_width", {31'b0, prev_vack}, 0);
        end
        prev_cack = cpu_ack;
        prev_vack = vid_ack;
    end

    // Issue one CPU access; lat counts negedges from raising req to seeing ack.
    task automatic cpu_op(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int nwe,
                          output logic [15:0] wadr);
        cpu_we = we; cpu_adr = adr; cpu_wdata = wd; cpu_req = 1'b1;
        lat = -1; nwe = 0; wadr = '0; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ram_we) begin nwe++; wadr = mem_adr; end
            if (cpu_ack) begin lat = k; rd = cpu_rdata; break; end
        end
        cpu_req = 1'b0;
        if (lat < 0) chk("cpu_ack_timeout", 0, 1);
    endtask

    task automatic vid_op(input logic [15:0] adr, output logic [7:0] rd, output int lat);
        vid_adr = adr; vid_req = 1'b1; lat = -1; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (vid_ack) begin lat = k; rd = vid_rdata; break; end
        end
        vid_req = 1'b0;
        if (lat < 0) chk("vid_ack_timeout", 0, 1);
    endtask

    function automatic logic [15:0] rand_adr();
        if ($urandom_range(0, 3) == 0) return 16'hF000 + 16'($urandom_range(0, 3));
        return 16'h0100 + 16'($urandom_range(0, 7));
    endfunction

    task automatic cpu_rand(input int n);
        logic [7:0] rd; int lat, nwe; logic [15:0] wa, a; logic we; logic [7:0] wd;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a = rand_adr(); we = 1'($urandom_range(0, 1)); wd = 8'($urandom);
            cpu_op(we, a, wd, rd, lat, nwe, wa);
            if (we) begin
                chk("rnd_cpu_we_cnt", nwe, (a >= 16'hF000) ? 0 : 1);
                if (a < 16'hF000) ref_mem[a] = wd;
            end else begin
                chk("rnd_cpu_rdata", rd, expect_rd(a));
            end
            chk("rnd_cpu_lat_ok", {31'b0, lat >= 3 && lat <= 9}, 1);
        end
    endtask

    task automatic vid_rand(input int n);
        logic [7:0] rd; int lat; logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a = rand_adr();
            vid_op(a, rd, lat);
            chk("rnd_vid_rdata", rd, expect_rd(a));
            chk("rnd_vid_lat_ok", {31'b0, lat >= 3 && lat <= 9}, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [7:0] rd; int lat, nwe; logic [15:0] wa;
        string seq; int c3, v3;

        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'(i) ^ 8'h33;
            ref_mem[i] = 8'(i) ^ 8'h33;
        end
        ram[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        ram[16'h0400] = 8'h5C; ref_mem[16'h0400] = 8'h5C;
        ram[16'hF000] = 8'h11;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {cpu_ack, vid_ack}, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_rdata", {cpu_rdata, vid_rdata}, 0);
        res_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // CPU read from RAM
        cpu_op(1'b0, 16'h0010, 8'h00, rd, lat, nwe, wa);
        chk("cpu_rd_lat", lat, 3);
        chk("cpu_rd_data", rd, 8'hA5);
        chk("cpu_rd_no_we", nwe, 0);

        // CPU write then read back
        cpu_op(1'b1, 16'h0200, 8'h3C, rd, lat, nwe, wa);
        ref_mem[16'h0200] = 8'h3C;
        chk("cpu_wr_lat", lat, 3);
        chk("cpu_wr_we_cnt", nwe, 1);
        chk("cpu_wr_we_adr", wa, 16'h0200);
        cpu_op(1'b0, 16'h0200, 8'h00, rd, lat, nwe, wa);
        chk("cpu_wr_readback", rd, 8'h3C);

        // ROM region: write discarded, read returns ROM data
        cpu_op(1'b1, 16'hF000, 8'hFF, rd, lat, nwe, wa);
        chk("rom_wr_we_cnt", nwe, 0);
        chk("rom_wr_lat", lat, 3);
        chk("rom_ram_untouched", ram[16'hF000], 8'h11);
        cpu_op(1'b0, 16'hF000, 8'h00, rd, lat, nwe, wa);
        chk("rom_rd_data", rd, 8'hEA);

        // Video read; CPU read data must hold
        vid_op(16'h0010, rd, lat);
        chk("vid_rd_lat", lat, 3);
        chk("vid_rd_data", rd, 8'hA5);
        chk("cpu_rdata_hold", cpu_rdata, 8'hEA);

        // Reset in the middle of an access
        cpu_we = 1'b0; cpu_adr = 16'h0010; cpu_req = 1'b1;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        res_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acks", {cpu_ack, vid_ack}, 0);
        chk("mid_rst_ram_we", ram_we, 0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        c3 = 0;
        repeat (8) begin @(negedge clk); if (cpu_ack) c3++; end
        chk("mid_rst_no_ack", c3, 0);

        // Contention from reset, both requests held
        res_n = 1'b0;
        cpu_we = 1'b0; cpu_adr = 16'h0200; cpu_req = 1'b1;
        vid_adr = 16'h0010; vid_req = 1'b1;
        @(negedge clk);
        res_n = 1'b1;
        seq = "";
        for (int k = 0; k < 40 && seq.len() < 8; k++) begin
            @(negedge clk);
            if (cpu_ack) begin seq = {seq, "C"}; chk("cont_cpu_data", cpu_rdata, 8'h3C); end
            if (vid_ack) begin seq = {seq, "V"}; chk("cont_vid_data", vid_rdata, 8'hA5); end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        n_tot++;
        if (seq != "CVCVCVCV") begin
            n_bad++;
            $display("FAIL cont_order: got=%s exp=CVCVCVCV", seq);
        end
        repeat (4) @(negedge clk);

        // Random traffic from both requesters
        fork
            cpu_rand(60);
            vid_rand(60);
        join
        mon_en = 1'b0;

        // MEM_LAT=3: video read, CPU request arrives mid-access
        vid_adr3 = 16'h0400; vid_req3 = 1'b1;
        c3 = -1; v3 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) begin cpu_we3 = 1'b0; cpu_adr3 = 16'h0010; cpu_req3 = 1'b1; end
            if (vid_ack3 && v3 < 0) begin
                v3 = k; vid_req3 = 1'b0;
                chk("lat3_vid_data", vid_rdata3, 8'h5C);
            end
            if (cpu_ack3 && c3 < 0) begin
                c3 = k; cpu_req3 = 1'b0;
                chk("lat3_cpu_data", cpu_rdata3, 8'hA5);
            end
            if (c3 > 0 && v3 > 0) break;
        end
        vid_req3 = 1'b0; cpu_req3 = 1'b0;
        chk("lat3_vid_lat", v3, 5);
        chk("lat3_cpu_after_done", c3, 10);
        chk("lat3_no_we", ram_we3, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
